// File: rtl/lsu.sv
// Load/store unit in front of the PikaCPU dmem: byte-address to word-access translation,
// load lane extraction and extension, read-modify-write for sub-word stores, misalign flagging.
module lsu #(
   parameter int ADDR_W = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_error,
   output logic [ADDR_W-3:0] mem_address,
   output logic [31:0]       mem_dataIn,
   output logic              mem_writeEnable,
   input  logic [31:0]       mem_dataOut
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            r_state, w_state_nx;
   logic              r_write, w_write_nx;
   logic [1:0]        r_size, w_size_nx;
   logic              r_signed, w_signed_nx;
   logic [1:0]        r_lane, w_lane_nx;
   logic [31:0]       r_wdata, w_wdata_nx;
   logic [ADDR_W-3:0] r_mem_address, w_mem_address_nx;
   logic [31:0]       r_mem_din, w_mem_din_nx;
   logic              r_mem_we, w_mem_we_nx;
   logic              r_resp_valid, w_resp_valid_nx;
   logic [31:0]       r_resp_rdata, w_resp_rdata_nx;
   logic              r_resp_error, w_resp_error_nx;
   logic              w_req_bad;

   function automatic logic [31:0] f_extend(input logic [31:0] word, input logic [1:0] size,
                                            input logic sgn, input logic [1:0] lane);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   return sgn ? {{24{b[7]}}, b} : {24'h000000, b};
         2'b01:   return sgn ? {{16{h[15]}}, h} : {16'h0000, h};
         default: return word;
      endcase
   endfunction

   function automatic logic [31:0] f_merge(input logic [31:0] old_word, input logic [31:0] wdata,
                                           input logic [1:0] size, input logic [1:0] lane);
      logic [31:0] w;
      w = old_word;
      case (size)
         2'b00: w[{lane, 3'b000} +: 8] = wdata[7:0];
         2'b01: begin
            if (lane[1]) begin
               w[31:16] = wdata[15:0];
            end else begin
               w[15:0] = wdata[15:0];
            end
         end
         default: w = wdata;
      endcase
      return w;
   endfunction

   assign w_req_bad = (req_size == 2'b11) ||
                      ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

   // Next-state and next-output decode; strobes default low, everything else holds.
   always_comb begin
      w_state_nx       = r_state;
      w_write_nx       = r_write;
      w_size_nx        = r_size;
      w_signed_nx      = r_signed;
      w_lane_nx        = r_lane;
      w_wdata_nx       = r_wdata;
      w_mem_address_nx = r_mem_address;
      w_mem_din_nx     = r_mem_din;
      w_mem_we_nx      = 1'b0;
      w_resp_valid_nx  = 1'b0;
      w_resp_rdata_nx  = r_resp_rdata;
      w_resp_error_nx  = r_resp_error;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_write_nx       = req_write;
               w_size_nx        = req_size;
               w_signed_nx      = req_signed;
               w_lane_nx        = req_addr[1:0];
               w_wdata_nx       = req_wdata;
               w_mem_address_nx = req_addr[ADDR_W-1:2];
               if (w_req_bad) begin
                  w_state_nx      = DONE;
                  w_resp_valid_nx = 1'b1;
                  w_resp_error_nx = 1'b1;
                  w_resp_rdata_nx = 32'h0000_0000;
               end else if (req_write && (req_size == 2'b10)) begin
                  w_state_nx   = WR;
                  w_mem_din_nx = req_wdata;
                  w_mem_we_nx  = 1'b1;
               end else begin
                  w_state_nx = RD;
               end
            end else begin
               w_state_nx = IDLE;
            end
         end
         RD: begin
            // mem_dataOut is combinational from the registered address, valid throughout RD.
            if (r_write) begin
               w_state_nx   = WR;
               w_mem_din_nx = f_merge(mem_dataOut, r_wdata, r_size, r_lane);
               w_mem_we_nx  = 1'b1;
            end else begin
               w_state_nx      = DONE;
               w_resp_valid_nx = 1'b1;
               w_resp_error_nx = 1'b0;
               w_resp_rdata_nx = f_extend(mem_dataOut, r_size, r_signed, r_lane);
            end
         end
         WR: begin
            w_state_nx      = DONE;
            w_resp_valid_nx = 1'b1;
            w_resp_error_nx = 1'b0;
            w_resp_rdata_nx = 32'h0000_0000;
         end
         DONE: begin
            w_state_nx = IDLE;
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   // State and registered outputs; async reset drops the write strobe immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_write       <= 1'b0;
         r_size        <= 2'b00;
         r_signed      <= 1'b0;
         r_lane        <= 2'b00;
         r_wdata       <= 32'h0000_0000;
         r_mem_address <= '0;
         r_mem_din     <= 32'h0000_0000;
         r_mem_we      <= 1'b0;
         r_resp_valid  <= 1'b0;
         r_resp_rdata  <= 32'h0000_0000;
         r_resp_error  <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_write       <= w_write_nx;
         r_size        <= w_size_nx;
         r_signed      <= w_signed_nx;
         r_lane        <= w_lane_nx;
         r_wdata       <= w_wdata_nx;
         r_mem_address <= w_mem_address_nx;
         r_mem_din     <= w_mem_din_nx;
         r_mem_we      <= w_mem_we_nx;
         r_resp_valid  <= w_resp_valid_nx;
         r_resp_rdata  <= w_resp_rdata_nx;
         r_resp_error  <= w_resp_error_nx;
      end
   end

   assign req_ready       = (r_state == IDLE);
   assign resp_valid      = r_resp_valid;
   assign resp_rdata      = r_resp_rdata;
   assign resp_error      = r_resp_error;
   assign mem_address     = r_mem_address;
   assign mem_dataIn      = r_mem_din;
   assign mem_writeEnable = r_mem_we;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a small behavioural dmem model.
module tb_lsu;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [23:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic [21:0] mem_address;
   logic [31:0] mem_dataIn;
   logic        mem_writeEnable;
   logic [31:0] mem_dataOut;

   logic [31:0] mem [0:63];
   int n_tests = 0;
   int n_fail  = 0;

   lsu #(.ADDR_W(24)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_error(resp_error), .mem_address(mem_address), .mem_dataIn(mem_dataIn),
      .mem_writeEnable(mem_writeEnable), .mem_dataOut(mem_dataOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_dataOut = mem[mem_address[5:0]];

   // dmem write port
   always @(posedge clk) begin
      if (mem_writeEnable) mem[mem_address[5:0]] <= mem_dataIn;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   int          lat, we_cnt;
   logic [31:0] din, rdata;
   logic [21:0] we_addr;
   logic        err;

   // Issue one request and follow it to its response (bounded at 8 cycles).
   task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [23:0] addr, input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
      req_addr = addr; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = -1; we_cnt = 0; din = 32'h0; rdata = 32'h0; err = 1'b0; we_addr = 22'h0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (mem_writeEnable) begin
            we_cnt++; din = mem_dataIn; we_addr = mem_address;
         end
         if (resp_valid) begin
            lat = c; rdata = resp_rdata; err = resp_error;
            break;
         end
      end
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 24'h0; req_wdata = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'h0, req_ready}, 32'd1);
      chk("rst_valid", {31'h0, resp_valid}, 32'd0);
      chk("rst_we", {31'h0, mem_writeEnable}, 32'd0);
      chk("rst_addr", {10'h0, mem_address}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'h0);
      reset = 1'b1;

      issue(1'b1, 2'b10, 1'b0, 24'h000010, 32'hDEADBEEF);
      chk("wst_lat", 32'(lat), 32'd2);
      chk("wst_we_cnt", 32'(we_cnt), 32'd1);
      chk("wst_we_addr", {10'h0, we_addr}, 32'h4);
      chk("wst_din", din, 32'hDEADBEEF);
      chk("wst_err", {31'h0, err}, 32'd0);
      issue(1'b0, 2'b10, 1'b0, 24'h000010, 32'h0);
      chk("wld_lat", 32'(lat), 32'd2);
      chk("wld_rdata", rdata, 32'hDEADBEEF);
      chk("wld_we_cnt", 32'(we_cnt), 32'd0);

      issue(1'b1, 2'b10, 1'b0, 24'h000010, 32'h11223344);
      issue(1'b1, 2'b00, 1'b0, 24'h000012, 32'h000000AA);
      chk("bst_lat", 32'(lat), 32'd3);
      chk("bst_din", din, 32'h11AA3344);
      chk("bst_we_cnt", 32'(we_cnt), 32'd1);
      chk("bst_rdata", rdata, 32'h0);
      issue(1'b0, 2'b10, 1'b0, 24'h000010, 32'h0);
      chk("bst_readback", rdata, 32'h11AA3344);

      issue(1'b1, 2'b10, 1'b0, 24'h000020, 32'h80FF7F01);
      issue(1'b0, 2'b00, 1'b1, 24'h000022, 32'h0);
      chk("lbs_lane2", rdata, 32'hFFFFFFFF);
      chk("lbs_lat", 32'(lat), 32'd2);
      issue(1'b0, 2'b00, 1'b0, 24'h000023, 32'h0);
      chk("lbu_lane3", rdata, 32'h00000080);
      issue(1'b0, 2'b01, 1'b1, 24'h000020, 32'h0);
      chk("lhs_lo", rdata, 32'h00007F01);
      issue(1'b0, 2'b01, 1'b1, 24'h000022, 32'h0);
      chk("lhs_hi", rdata, 32'hFFFF80FF);
      issue(1'b1, 2'b01, 1'b0, 24'h000022, 32'h1234BEEF);
      chk("hst_din", din, 32'hBEEF7F01);
      chk("hst_lat", 32'(lat), 32'd3);

      issue(1'b1, 2'b10, 1'b0, 24'h000013, 32'h12345678);
      chk("mis_w_err", {31'h0, err}, 32'd1);
      chk("mis_w_lat", 32'(lat), 32'd1);
      chk("mis_w_rdata", rdata, 32'h0);
      chk("mis_w_we", 32'(we_cnt), 32'd0);
      issue(1'b0, 2'b01, 1'b0, 24'h000001, 32'h0);
      chk("mis_h_err", {31'h0, err}, 32'd1);
      chk("mis_h_lat", 32'(lat), 32'd1);
      issue(1'b1, 2'b11, 1'b0, 24'h000010, 32'hFFFFFFFF);
      chk("rsv_err", {31'h0, err}, 32'd1);
      chk("rsv_we", 32'(we_cnt), 32'd0);
      issue(1'b0, 2'b10, 1'b0, 24'h000010, 32'h0);
      chk("mis_unchanged", rdata, 32'h11AA3344);
      chk("ok_err_clear", {31'h0, err}, 32'd0);

      // backpressure: second request held valid while the first is in flight
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 24'h000023; req_wdata = 32'h0;
      @(posedge clk);
      #1 req_size = 2'b10; req_addr = 24'h000020;
      @(negedge clk);
      chk("bp_c1_ready", {31'h0, req_ready}, 32'd0);
      chk("bp_c1_valid", {31'h0, resp_valid}, 32'd0);
      @(negedge clk);
      chk("bp_c2_valid", {31'h0, resp_valid}, 32'd1);
      chk("bp_c2_rdata", resp_rdata, 32'h000000BE);
      chk("bp_c2_ready", {31'h0, req_ready}, 32'd0);
      @(negedge clk);
      chk("bp_c3_ready", {31'h0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("bp_c4_ready", {31'h0, req_ready}, 32'd0);
      chk("bp_c4_valid", {31'h0, resp_valid}, 32'd0);
      @(negedge clk);
      chk("bp_c5_valid", {31'h0, resp_valid}, 32'd1);
      chk("bp_c5_rdata", resp_rdata, 32'hBEEF7F01);

      // reset abort during RD of a byte store
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
      req_addr = 24'h000010; req_wdata = 32'h00000055;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_we", {31'h0, mem_writeEnable}, 32'd0);
      chk("abort_ready", {31'h0, req_ready}, 32'd1);
      chk("abort_rdata", resp_rdata, 32'h0);
      chk("abort_addr", {10'h0, mem_address}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("abort_no_valid", {31'h0, resp_valid | mem_writeEnable}, 32'd0);
      end
      reset = 1'b1;
      issue(1'b0, 2'b10, 1'b0, 24'h000010, 32'h0);
      chk("abort_readback", rdata, 32'h11AA3344);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
